// File: rtl/pc_fetch_unit.sv
// Fetch stage: drives the PC to instruction memory and buffers up to two fetched words for decode.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect halts fetch and raises misalign_err.

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_flag,
    input  logic [31:0] jump_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        outstanding_q, outstanding_d;
    logic        kill_q, kill_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_inst_q, head_inst_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] tail_inst_q, tail_inst_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic        req_valid_q, req_valid_d;
    logic        id_valid_q, id_valid_d;
    logic        misalign_q, misalign_d;

    logic        req_fire;
    logic        rsp_fire;
    logic        push;
    logic        pop;
    logic        jump_bad;
    logic [31:0] jump_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign jump_bad = jump_flag & (jump_target[1:0] != 2'b00);
    assign jump_pc  = jump_target;
`else
    assign jump_bad = 1'b0;
    assign jump_pc  = jump_target & 32'hFFFF_FFFC;
`endif

    assign req_fire = req_valid_q & imem_req_ready;
    assign rsp_fire = (state_q == StWait) & imem_rsp_valid;
    // A redirect in this cycle overrides both the incoming push and the decode pop.
    assign push     = rsp_fire & ~kill_q & ~jump_flag;
    assign pop      = id_valid_q & id_ready & ~jump_flag;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;
        count_d       = count_q;
        head_inst_d   = head_inst_q;
        head_pc_d     = head_pc_q;
        tail_inst_d   = tail_inst_q;
        tail_pc_d     = tail_pc_q;
        misalign_d    = misalign_q;

        case (state_q)
            StIdle: begin
                if (!misalign_q) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (req_fire) begin
                    outstanding_d = 1'b1;
                    fetch_pc_d    = pc_q;
                    pc_d          = pc_q + 32'd4;
                    state_d       = StWait;
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    outstanding_d = 1'b0;
                    kill_d        = 1'b0;
                    state_d       = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Two-entry FIFO kept as head/tail so the head drives id_inst/id_pc directly.
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_inst_d = imem_rsp_data;
                    head_pc_d   = fetch_pc_q;
                end else begin
                    tail_inst_d = imem_rsp_data;
                    tail_pc_d   = fetch_pc_q;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_inst_d = tail_inst_q;
                head_pc_d   = tail_pc_q;
                count_d     = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_inst_d = imem_rsp_data;
                    head_pc_d   = fetch_pc_q;
                end else begin
                    head_inst_d = tail_inst_q;
                    head_pc_d   = tail_pc_q;
                    tail_inst_d = imem_rsp_data;
                    tail_pc_d   = fetch_pc_q;
                end
            end
            default: begin
            end
        endcase

        if (jump_flag) begin
            count_d = 2'd0;
            pc_d    = jump_pc;
            // Anything still in flight after this edge belongs to the old stream.
            kill_d  = outstanding_d;
            if (jump_bad) begin
                pc_d          = pc_q;
                state_d       = StIdle;
                outstanding_d = 1'b0;
                kill_d        = 1'b0;
                misalign_d    = 1'b1;
            end
        end

        req_valid_d = (state_d == StReq) & ~outstanding_d & (count_d != 2'd2);
        id_valid_d  = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= 1'b0;
            kill_q        <= 1'b0;
            count_q       <= 2'd0;
            head_inst_q   <= 32'h0;
            head_pc_q     <= 32'h0;
            tail_inst_q   <= 32'h0;
            tail_pc_q     <= 32'h0;
            req_valid_q   <= 1'b0;
            id_valid_q    <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            count_q       <= count_d;
            head_inst_q   <= head_inst_d;
            head_pc_q     <= head_pc_d;
            tail_inst_q   <= tail_inst_d;
            tail_pc_q     <= tail_pc_d;
            req_valid_q   <= req_valid_d;
            id_valid_q    <= id_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign id_valid       = id_valid_q;
    assign id_inst        = head_inst_q;
    assign id_pc          = head_pc_q;
    assign misalign_err   = misalign_q;

endmodule
